// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM: byte enables, 1/2-cycle read latency, RDW mode, range check.
// Define RAM_ZERO_INIT_EN to sweep the array to zero after every reset (busy high meanwhile).
module ram_sp_param #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int RD_LAT      = 1,
  parameter int WRITE_FIRST = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [ADDR_W-1:0]   address_in,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                addr_err,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              busy_i;
  logic              rd_acc;
  logic              wr_acc;
  logic              err_acc;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_word;
  logic              clr_we;
  logic [IDX_W-1:0]  clr_ptr;

  assign in_range = ({1'b0, address_in} < (ADDR_W+1)'(DEPTH));
  assign idx      = in_range ? address_in[IDX_W-1:0] : '0;
  assign rd_acc   = read && !busy_i;
  assign wr_acc   = write && !busy_i && in_range;
  assign err_acc  = (read || write) && !busy_i && !in_range;
  assign old_word = mem[idx];

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  // Write-first returns the merged word; the array itself is only updated at the edge.
  assign rd_word = (WRITE_FIRST != 0 && wr_acc) ? merged : old_word;

`ifdef RAM_ZERO_INIT_EN
  // state | meaning
  // IDLE  | normal operation, busy low
  // CLEAR | writing zero to mem[clr_ptr], busy high
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  clr_state_t state;
  logic       busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == IDX_W'(DEPTH - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_i = busy_q;
  assign clr_we = (state == CLEAR) && !reset;
`else
  assign busy_i  = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_ptr = '0;
`endif

  assign busy = busy_i;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  logic              s1_valid;
  logic              s1_err;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      s1_err   <= err_acc;
      if (rd_acc) s1_data <= in_range ? rd_word : '0;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] s2_data;
      logic              s2_valid;
      logic              s2_err;

      always_ff @(posedge clk) begin
        if (reset) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_err;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign data_out = s2_data;
      assign rd_valid = s2_valid;
      assign addr_err = s2_err;
    end else begin : g_lat1
      assign data_out = s1_data;
      assign rd_valid = s1_valid;
      assign addr_err = s1_err;
    end
  endgenerate

endmodule

// File: doc/ram_sp_param.md
Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM for the memory subsystem.
- Generalises the fixed 512x32 RAM with:
  - configurable width and depth
  - per-byte write enables
  - selectable read latency (1 or 2 cycles) with a read-valid strobe
  - read-during-write mode selection
  - out-of-range address detection
- Serves as the processor's data/instruction store behind the MDR/MAR path.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 9, address width in bits
DEPTH, 512, number of words; 1 <= DEPTH <= 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2
WRITE_FIRST, 0, read-during-write to the same address: 0 returns old data, 1 returns new (merged) data

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active high
read  input  1  read request, sampled on posedge clk
write  input  1  write request, sampled on posedge clk
byte_en  input  DATA_W/8  per-byte write enable; bit i gates data_in[8i+7:8i]
address_in  input  ADDR_W  word address
data_in  input  DATA_W  write data
data_out  output  DATA_W  read data; holds its value until the next valid read
rd_valid  output  1  one-cycle pulse when data_out is updated
addr_err  output  1  one-cycle pulse, RD_LAT cycles after any read or write with address_in >= DEPTH
busy  output  1  high while the optional clear sweep runs; 0 when the feature is absent

Behaviour:
- Reset, sampled on posedge clk:
  - data_out = 0, rd_valid = 0, addr_err = 0, and the internal latency pipeline is cleared.
  - Array contents are not altered by reset, except under RAM_ZERO_INIT_EN.
- Write:
  - Occurs when write=1, busy=0 and address_in < DEPTH.
  - Each byte with byte_en[i]=1 takes data_in; bytes with byte_en[i]=0 keep their stored value.
  - write=1 with byte_en all 0 changes nothing and is not an error.
- Read:
  - Accepted when read=1 and busy=0.
  - RD_LAT=1: data_out and rd_valid update at the same edge the request is sampled, so they are visible the following cycle.
  - RD_LAT=2: an extra output register stage adds one further cycle.
  - Back-to-back reads are fully pipelined, one per cycle at any latency.
- Simultaneous read and write to the same address in one cycle:
  - WRITE_FIRST=0: data_out returns the pre-write word.
  - WRITE_FIRST=1: data_out returns the post-write word, including the byte_en merge.
- Out-of-range address (address_in >= DEPTH):
  - The write is dropped and the array is untouched.
  - A read produces data_out = 0 with rd_valid=1.
  - addr_err pulses aligned with where rd_valid would land; this applies to writes too.
  - If both read and write are asserted, addr_err pulses once.
- No read and no write: data_out holds, and rd_valid = 0.
- Reset asserted while reads are in flight: all pending rd_valid/addr_err pulses are discarded and none emerge after reset.
- While busy=1: read and write are ignored entirely, with no rd_valid and no addr_err.

Optional Feature:
- Macro: RAM_ZERO_INIT_EN.
- Defined:
  - A clear FSM with states IDLE and CLEAR.
  - Reset forces CLEAR, with the sweep pointer = 0 and busy=1.
  - Each cycle writes 0 to mem[pointer] and increments the pointer.
  - After writing DEPTH-1, the FSM goes to IDLE and busy drops the next cycle. The sweep takes exactly DEPTH cycles after reset deasserts.
  - Reset asserted mid-sweep restarts the sweep from address 0.
- Undefined:
  - No FSM, and busy is tied 0.
  - Array contents after power-up are undefined, so the bench must write before read.

Test Plan:
- Default params: write 0xDEADBEEF at addr 5 with byte_en=4'hF, then read 5 -> data_out=0xDEADBEEF with rd_valid high exactly 1 cycle after the read.
- Partial write: write 0x11223344 at addr 7 (byte_en F), then 0xAABBCCDD with byte_en=4'b0101, then read 7 -> 0x11BB33DD.
- Read-during-write at addr 3 (old 0x0, new 0x55): WRITE_FIRST=0 -> 0x00000000; WRITE_FIRST=1 -> 0x00000055.
- RD_LAT=2, reads of addrs 1, 2, 3 on consecutive cycles -> data appears on three consecutive cycles starting 2 cycles after the first request; reset asserted after the second request -> no further rd_valid pulses.
- DEPTH=300, ADDR_W=9: write to 400, then read 400 -> array unchanged, data_out=0, rd_valid=1, addr_err pulses once for the write and once for the read.
- RAM_ZERO_INIT_EN with DEPTH=16: after reset, busy stays high 16 cycles and a write issued during busy is ignored; afterwards, reads of all 16 addresses -> 0.
